// File: rtl/snake_pkg.sv
// Shared direction encodings, PS/2 scan codes and helper functions for the snake game.
package snake_pkg;

  localparam logic [4:0] DIR_NONE  = 5'b00000;
  localparam logic [4:0] DIR_UP    = 5'b00010;
  localparam logic [4:0] DIR_LEFT  = 5'b00100;
  localparam logic [4:0] DIR_DOWN  = 5'b01000;
  localparam logic [4:0] DIR_RIGHT = 5'b10000;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  function automatic logic [4:0] opposite(input logic [4:0] dir);
    logic [4:0] rev;
    case (dir)
      DIR_UP:    rev = DIR_DOWN;
      DIR_DOWN:  rev = DIR_UP;
      DIR_LEFT:  rev = DIR_RIGHT;
      DIR_RIGHT: rev = DIR_LEFT;
      default:   rev = DIR_NONE;
    endcase
    return rev;
  endfunction

  // Data byte plus its parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises KB_clk/data into VGA_clk, checks each 11-bit frame,
// and reports a received byte or a framing error as single-cycle pulses.
module ps2_frame_rx
  import snake_pkg::*;
#(
  parameter int TIMEOUT_CYC = 25000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       VGA_clk,
  input  logic       rst,
  input  logic       KB_clk,
  input  logic       data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] kb_sync_r, data_sync_r;
  logic                   kb_prev_r;
  logic                   fall_s, bit_s;
  rx_state_e              state_r, state_s;
  logic [2:0]             bit_cnt_r, bit_cnt_s;
  logic [7:0]             shreg_r, shreg_s, byte_r, byte_s;
  logic                   par_ok_r, par_ok_s;
  logic [TW-1:0]          tmo_r, tmo_s;
  logic                   byte_valid_r, byte_valid_s, frame_err_r, frame_err_s;

  assign fall_s     = kb_prev_r & ~kb_sync_r[SYNC_STAGES-1];
  assign bit_s      = data_sync_r[SYNC_STAGES-1];
  assign byte_data  = byte_r;
  assign byte_valid = byte_valid_r;
  assign frame_err  = frame_err_r;

  // Synchronisers, edge-detect history and all frame state registers.
  always_ff @(posedge VGA_clk) begin
    if (!rst) begin
      kb_sync_r    <= {SYNC_STAGES{1'b1}};
      data_sync_r  <= {SYNC_STAGES{1'b1}};
      kb_prev_r    <= 1'b1;
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      shreg_r      <= 8'h00;
      par_ok_r     <= 1'b0;
      tmo_r        <= '0;
      byte_r       <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      kb_sync_r    <= {kb_sync_r[SYNC_STAGES-2:0], KB_clk};
      data_sync_r  <= {data_sync_r[SYNC_STAGES-2:0], data};
      kb_prev_r    <= kb_sync_r[SYNC_STAGES-1];
      state_r      <= state_s;
      bit_cnt_r    <= bit_cnt_s;
      shreg_r      <= shreg_s;
      par_ok_r     <= par_ok_s;
      tmo_r        <= tmo_s;
      byte_r       <= byte_s;
      byte_valid_r <= byte_valid_s;
      frame_err_r  <= frame_err_s;
    end
  end

  // Frame FSM next-state, timeout and pulse generation.
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    shreg_s      = shreg_r;
    par_ok_s     = par_ok_r;
    tmo_s        = tmo_r;
    byte_s       = byte_r;
    byte_valid_s = 1'b0;
    frame_err_s  = 1'b0;
    if (state_r == ST_IDLE) begin
      tmo_s = '0;
    end else if (fall_s) begin
      tmo_s = '0;
    end else if (tmo_r == TMO_LAST) begin
      // Abort mid-frame; the partial byte is simply dropped.
      state_s     = ST_IDLE;
      frame_err_s = 1'b1;
      tmo_s       = '0;
    end else begin
      tmo_s = tmo_r + 1'b1;
    end
    if (fall_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!bit_s) begin
            state_s   = ST_DATA;
            bit_cnt_s = 3'd0;
          end else begin
            frame_err_s = 1'b1;
          end
        end
        ST_DATA: begin
          shreg_s   = {bit_s, shreg_r[7:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_s = ST_PARITY;
          end else begin
            state_s = ST_DATA;
          end
        end
        ST_PARITY: begin
          par_ok_s = odd_parity_ok(shreg_r, bit_s);
          state_s  = ST_STOP;
        end
        ST_STOP: begin
          if (bit_s && par_ok_r) begin
            byte_valid_s = 1'b1;
            byte_s       = shreg_r;
          end else begin
            frame_err_s = 1'b1;
          end
          state_s = ST_IDLE;
        end
        default: state_s = ST_IDLE;
      endcase
    end else begin
      bit_cnt_s = bit_cnt_r;
    end
  end

endmodule

// File: rtl/ps2_direction_rx.sv
// PS/2 keyboard front end for the snake core: tracks E0/F0 prefixes, decodes WASD/arrow
// make codes into a one-hot direction, filters 180-degree reversals and flags space as restart.
module ps2_direction_rx
  import snake_pkg::*;
#(
  parameter int TIMEOUT_CYC = 25000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       VGA_clk,
  input  logic       rst,
  input  logic       KB_clk,
  input  logic       data,
  output logic [4:0] direction,
  output logic       dir_valid,
  output logic       restart,
  output logic       frame_err
);

  logic [7:0] byte_data_s;
  logic       byte_valid_s;
  logic       ext_r, ext_s, brk_r, brk_s;
  logic [4:0] direction_r, direction_s, cand_s;
  logic       cand_hit_s;
  logic       dir_valid_r, dir_valid_s, restart_r, restart_s;

  ps2_frame_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_frame (
    .VGA_clk   (VGA_clk),
    .rst       (rst),
    .KB_clk    (KB_clk),
    .data      (data),
    .byte_data (byte_data_s),
    .byte_valid(byte_valid_s),
    .frame_err (frame_err)
  );

  assign direction = direction_r;
  assign dir_valid = dir_valid_r;
  assign restart   = restart_r;

  // Prefix flags and registered direction/pulse outputs.
  always_ff @(posedge VGA_clk) begin
    if (!rst) begin
      ext_r       <= 1'b0;
      brk_r       <= 1'b0;
      direction_r <= DIR_NONE;
      dir_valid_r <= 1'b0;
      restart_r   <= 1'b0;
    end else begin
      ext_r       <= ext_s;
      brk_r       <= brk_s;
      direction_r <= direction_s;
      dir_valid_r <= dir_valid_s;
      restart_r   <= restart_s;
    end
  end

  // Scan-code decode, prefix tracking and reversal filter.
  always_comb begin
    ext_s       = ext_r;
    brk_s       = brk_r;
    cand_s      = DIR_NONE;
    cand_hit_s  = 1'b0;
    restart_s   = 1'b0;
    direction_s = direction_r;
    dir_valid_s = 1'b0;
    if (byte_valid_s) begin
      if (byte_data_s == SC_E0) begin
        ext_s = 1'b1;
      end else if (byte_data_s == SC_F0) begin
        brk_s = 1'b1;
      end else begin
        ext_s = 1'b0;
        brk_s = 1'b0;
        if (brk_r) begin
          cand_hit_s = 1'b0;
        end else if (ext_r) begin
          case (byte_data_s)
            SC_UP:    begin cand_s = DIR_UP;    cand_hit_s = 1'b1; end
            SC_LEFT:  begin cand_s = DIR_LEFT;  cand_hit_s = 1'b1; end
            SC_DOWN:  begin cand_s = DIR_DOWN;  cand_hit_s = 1'b1; end
            SC_RIGHT: begin cand_s = DIR_RIGHT; cand_hit_s = 1'b1; end
            default:  cand_hit_s = 1'b0;
          endcase
        end else begin
          case (byte_data_s)
            SC_W:     begin cand_s = DIR_UP;    cand_hit_s = 1'b1; end
            SC_A:     begin cand_s = DIR_LEFT;  cand_hit_s = 1'b1; end
            SC_S:     begin cand_s = DIR_DOWN;  cand_hit_s = 1'b1; end
            SC_D:     begin cand_s = DIR_RIGHT; cand_hit_s = 1'b1; end
            SC_ESC:   begin cand_s = DIR_NONE;  cand_hit_s = 1'b1; end
            SC_SPACE: restart_s = 1'b1;
            default:  cand_hit_s = 1'b0;
          endcase
        end
      end
    end else begin
      cand_hit_s = 1'b0;
    end
    // Centre has no opposite, so it both accepts and can be chosen from any heading.
    if (cand_hit_s && (cand_s != direction_r) && (cand_s != opposite(direction_r))) begin
      direction_s = cand_s;
      dir_valid_s = 1'b1;
    end else begin
      dir_valid_s = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_direction_rx.sv
// Directed bench for ps2_direction_rx: drives PS/2 frames and checks direction and pulse outputs.
module tb_ps2_direction_rx;

  localparam int TMO = 25000;

  logic       VGA_clk = 1'b0;
  logic       rst = 1'b0;
  logic       KB_clk = 1'b1;
  logic       data = 1'b1;
  logic [4:0] direction;
  logic       dir_valid, restart, frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int dv_cnt = 0;
  int rs_cnt = 0;
  int fe_cnt = 0;

  ps2_direction_rx #(.TIMEOUT_CYC(TMO), .SYNC_STAGES(2)) dut (
    .VGA_clk  (VGA_clk),
    .rst      (rst),
    .KB_clk   (KB_clk),
    .data     (data),
    .direction(direction),
    .dir_valid(dir_valid),
    .restart  (restart),
    .frame_err(frame_err)
  );

  always #20 VGA_clk = ~VGA_clk;

  always @(negedge VGA_clk) begin
    if (dir_valid) dv_cnt++;
    if (restart)   rs_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge VGA_clk);
  endtask

  task automatic send_bit(input logic b);
    data = b;
    cycles(4);
    KB_clk = 1'b0;
    cycles(8);
    KB_clk = 1'b1;
    cycles(4);
  endtask

  // Sends the first nbits of a frame built LSB-first: start, 8 data, odd parity, stop.
  task automatic send_frame(input logic [7:0] b, input logic flip_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i]);
    data = 1'b1;
    cycles(10);
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic clr;
    dv_cnt = 0;
    rs_cnt = 0;
    fe_cnt = 0;
  endtask

  initial begin
    cycles(3);
    check("rst_dir", direction, 5'b00000);
    check("rst_dv", dir_valid, 1'b0);
    check("rst_rs", restart, 1'b0);
    check("rst_fe", frame_err, 1'b0);
    rst = 1'b1;
    cycles(5);

    // T1
    clr(); key(8'h1D);
    check("t1_dir", direction, 5'b00010);
    check("t1_dv", dv_cnt, 1);
    clr(); key(8'h1D);
    check("t1_rep_dir", direction, 5'b00010);
    check("t1_rep_dv", dv_cnt, 0);

    // T2
    clr(); key(8'h1B);
    check("t2_rev_dir", direction, 5'b00010);
    check("t2_rev_dv", dv_cnt, 0);
    clr(); key(8'h1C);
    check("t2_left_dir", direction, 5'b00100);
    check("t2_left_dv", dv_cnt, 1);

    // T3: head up first so the right arrow is not a reversal
    key(8'h1D);
    check("t3_pre_dir", direction, 5'b00010);
    clr(); key(8'hE0); key(8'h74);
    check("t3_right_dir", direction, 5'b10000);
    check("t3_right_dv", dv_cnt, 1);
    clr(); key(8'hE0); key(8'hF0); key(8'h74);
    check("t3_brk_dir", direction, 5'b10000);
    check("t3_brk_dv", dv_cnt, 0);

    // T4
    clr(); send_frame(8'h23, 1'b1, 11);
    check("t4_par_fe", fe_cnt, 1);
    check("t4_par_dir", direction, 5'b10000);
    check("t4_par_dv", dv_cnt, 0);
    clr(); key(8'h76);
    check("t4_ctr_dir", direction, 5'b00000);
    check("t4_ctr_dv", dv_cnt, 1);
    check("t4_ctr_fe", fe_cnt, 0);

    // T5
    clr(); send_frame(8'h1D, 1'b0, 5);
    check("t5_pre_fe", fe_cnt, 0);
    cycles(TMO + 20);
    check("t5_tmo_fe", fe_cnt, 1);
    clr(); key(8'h29);
    check("t5_rs", rs_cnt, 1);
    check("t5_dir", direction, 5'b00000);
    check("t5_dv", dv_cnt, 0);
    check("t5_fe", fe_cnt, 0);

    // T6
    key(8'h1C);
    check("t6_pre_dir", direction, 5'b00100);
    send_frame(8'h23, 1'b0, 6);
    rst = 1'b0;
    cycles(3);
    check("t6_rst_dir", direction, 5'b00000);
    check("t6_rst_dv", dir_valid, 1'b0);
    check("t6_rst_rs", restart, 1'b0);
    check("t6_rst_fe", frame_err, 1'b0);
    rst = 1'b1;
    cycles(5);
    clr(); key(8'h1D);
    check("t6_dir", direction, 5'b00010);
    check("t6_dv", dv_cnt, 1);
    check("t6_fe", fe_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
